// File: rtl/dla_platform_csr_axi_stub_if.sv
// AXI4-Lite CSR port bundle between the platform CSR interconnect and the
// stub.
// wdata/wstrb are deliberately absent because the stub discards write data.
// The master modport is the interconnect side and the slave modport is the
// stub side.
interface dla_platform_csr_axi_stub_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 1
);
   // Read address channel
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;

   // Read data channel
   logic                  rvalid;
   logic                  rready;
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;

   // Write address channel
   logic                  awvalid;
   logic                  awready;
   logic [ID_WIDTH-1:0]   awid;

   // Write data channel
   logic                  wvalid;
   logic                  wready;

   // Write response channel
   logic                  bvalid;
   logic                  bready;
   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;

   modport master (
      output arvalid, arid, araddr, rready,
      output awvalid, awid, wvalid, bready,
      input  arready, rvalid, rid, rdata, rresp,
      input  awready, wready, bvalid, bid, bresp
   );

   modport slave (
      input  arvalid, arid, araddr, rready,
      input  awvalid, awid, wvalid, bready,
      output arready, rvalid, rid, rdata, rresp,
      output awready, wready, bvalid, bid, bresp
   );
endinterface

// File: rtl/dla_platform_csr_axi_stub.sv
// CSR slave stub that completes every AXI4-Lite transaction aimed at an
// unpopulated CoreDLA instance slot.
// Read ids and write ids are echoed back unchanged.
// Every B and R beat carries the configured response code.
// Read data is either a fixed pattern or the captured read address.
// Saturating counters and a sticky flag let software see that the empty slot
// was touched.

// Reset conditioner.
// Assertion passes through asynchronously.
// Release is synchronised to clk, optionally followed by extra pipeline
// stages.
module dla_reset_handler_simple #(
   parameter int USE_SYNCHRONIZER = 1,
   parameter int PIPE_DEPTH       = 0
) (
   input  logic clk,
   input  logic i_resetn,
   output logic o_sclrn
);
   localparam int SYNC_DEPTH = 2;

   logic sync_resetn;

   generate
      if (USE_SYNCHRONIZER != 0) begin : g_sync
         logic [SYNC_DEPTH-1:0] sync_q;

         // Clear the chain at once when reset asserts.
         // Shift ones in so that release only reaches o_sclrn after the
         // chain has filled.
         always_ff @(posedge clk or negedge i_resetn) begin
            if (!i_resetn) begin
               sync_q <= '0;
            end else begin
               sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
            end
         end

         assign sync_resetn = sync_q[SYNC_DEPTH-1];
      end else begin : g_nosync
         assign sync_resetn = i_resetn;
      end
   endgenerate

   generate
      if (PIPE_DEPTH > 0) begin : g_pipe
         logic [PIPE_DEPTH-1:0] pipe_q;

         // Optional retiming stages.
         // These give the reset fan-out room to be placed across the chip.
         always_ff @(posedge clk) begin
            pipe_q[0] <= sync_resetn;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
               pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign o_sclrn = pipe_q[PIPE_DEPTH-1];
      end else begin : g_nopipe
         assign o_sclrn = sync_resetn;
      end
   endgenerate
endmodule

module dla_platform_csr_axi_stub #(
   parameter int          CSR_ADDR_WIDTH = 11,
   parameter int          CSR_DATA_WIDTH = 32,
   parameter int          ID_WIDTH       = 1,
   parameter logic [1:0]  RESP           = 2'b00,
   parameter int          RDATA_MODE     = 0,
   parameter logic [31:0] RDATA_PATTERN  = 32'hDEAD_C5A0,
   parameter int          COUNT_WIDTH    = 16
) (
   input  logic                       clk,
   input  logic                       i_resetn_async,
   dla_platform_csr_axi_stub_if.slave csr,
   output logic [COUNT_WIDTH-1:0]     o_rd_count,
   output logic [COUNT_WIDTH-1:0]     o_wr_count,
   output logic                       o_accessed
);
   // Fixed read data, zero-extended or truncated to the bus width.
   localparam logic [CSR_DATA_WIDTH-1:0] PATTERN   = CSR_DATA_WIDTH'(RDATA_PATTERN);
   localparam logic [COUNT_WIDTH-1:0]    COUNT_MAX = {COUNT_WIDTH{1'b1}};

   logic sclrn;

   // Read path state
   logic                      rd_busy;
   logic [ID_WIDTH-1:0]       rid_q;
   logic [CSR_ADDR_WIDTH-1:0] raddr_q;

   // Write path state
   logic                      aw_held;
   logic                      w_held;
   logic [ID_WIDTH-1:0]       awid_q;
   logic                      bvalid_q;
   logic [ID_WIDTH-1:0]       bid_q;

   // Status state
   logic [COUNT_WIDTH-1:0]    rd_count_q;
   logic [COUNT_WIDTH-1:0]    wr_count_q;
   logic                      accessed_q;

   // Ready and handshake decodes
   logic arready;
   logic awready;
   logic wready;
   logic ar_hs;
   logic r_hs;
   logic aw_hs;
   logic w_hs;
   logic b_hs;

   dla_reset_handler_simple #(
      .USE_SYNCHRONIZER (1),
      .PIPE_DEPTH       (0)
   ) u_reset (
      .clk      (clk),
      .i_resetn (i_resetn_async),
      .o_sclrn  (sclrn)
   );

   // Readies are single-gate decodes of flops.
   // There is no combinational path from any bus input.
   // Gating with sclrn keeps the slot closed while reset is held.
   assign arready = sclrn & ~rd_busy;
   assign awready = sclrn & ~aw_held & ~bvalid_q;
   assign wready  = sclrn & ~w_held  & ~bvalid_q;

   assign ar_hs = csr.arvalid & arready;
   assign r_hs  = rd_busy     & csr.rready;
   assign aw_hs = csr.awvalid & awready;
   assign w_hs  = csr.wvalid  & wready;
   assign b_hs  = bvalid_q    & csr.bready;

   assign csr.arready = arready;
   assign csr.rvalid  = rd_busy;
   assign csr.rid     = rid_q;
   assign csr.rresp   = RESP;
   assign csr.rdata   = (RDATA_MODE != 0) ? CSR_DATA_WIDTH'(raddr_q) : PATTERN;

   assign csr.awready = awready;
   assign csr.wready  = wready;
   assign csr.bvalid  = bvalid_q;
   assign csr.bid     = bid_q;
   assign csr.bresp   = RESP;

   assign o_rd_count = rd_count_q;
   assign o_wr_count = wr_count_q;
   assign o_accessed = accessed_q;

   // Single outstanding read.
   // Capture id and address on AR, then hold the R beat until the master
   // takes it.
   always_ff @(posedge clk) begin
      if (!sclrn) begin
         rd_busy <= 1'b0;
         rid_q   <= '0;
         raddr_q <= '0;
      end else if (ar_hs) begin
         rd_busy <= 1'b1;
         rid_q   <= csr.arid;
         raddr_q <= csr.araddr;
      end else if (r_hs) begin
         rd_busy <= 1'b0;
      end
   end

   // Write tracking.
   // AW and W are latched independently, in either order.
   // Once both are latched a B beat is raised on the next edge and then held
   // until accepted.
   always_ff @(posedge clk) begin
      if (!sclrn) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         awid_q   <= '0;
         bvalid_q <= 1'b0;
         bid_q    <= '0;
      end else if (bvalid_q) begin
         if (csr.bready) begin
            bvalid_q <= 1'b0;
         end
      end else if (aw_held && w_held) begin
         bvalid_q <= 1'b1;
         bid_q    <= awid_q;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_held <= 1'b1;
            awid_q  <= csr.awid;
         end
         if (w_hs) begin
            w_held <= 1'b1;
         end
      end
   end

   // Completion counters stick at all-ones instead of wrapping.
   // This way a heavily touched slot never reads back as untouched.
   always_ff @(posedge clk) begin
      if (!sclrn) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         if (r_hs && (rd_count_q != COUNT_MAX)) begin
            rd_count_q <= rd_count_q + COUNT_WIDTH'(1);
         end
         if (b_hs && (wr_count_q != COUNT_MAX)) begin
            wr_count_q <= wr_count_q + COUNT_WIDTH'(1);
         end
      end
   end

   // Sticky access flag.
   // It is raised by the first accepted address on either path.
   always_ff @(posedge clk) begin
      if (!sclrn) begin
         accessed_q <= 1'b0;
      end else if (ar_hs || aw_hs) begin
         accessed_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dla_platform_csr_axi_stub.sv
// Directed bench for the CSR stub.
// Instance a uses pattern read data, OKAY responses and 16-bit counters.
// Instance b uses address read data, DECERR responses and 2-bit counters.
module tb_dla_platform_csr_axi_stub;
   logic clk = 1'b0;
   logic resetn;

   always #5 clk = ~clk;

   dla_platform_csr_axi_stub_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .ID_WIDTH(1)) bus_a ();
   dla_platform_csr_axi_stub_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .ID_WIDTH(1)) bus_b ();

   logic [15:0] rd_count_a;
   logic [15:0] wr_count_a;
   logic        accessed_a;
   logic [1:0]  rd_count_b;
   logic [1:0]  wr_count_b;
   logic        accessed_b;

   dla_platform_csr_axi_stub #(
      .CSR_ADDR_WIDTH (11),
      .CSR_DATA_WIDTH (32),
      .ID_WIDTH       (1),
      .RESP           (2'b00),
      .RDATA_MODE     (0),
      .RDATA_PATTERN  (32'hDEAD_C5A0),
      .COUNT_WIDTH    (16)
   ) dut_a (
      .clk            (clk),
      .i_resetn_async (resetn),
      .csr            (bus_a),
      .o_rd_count     (rd_count_a),
      .o_wr_count     (wr_count_a),
      .o_accessed     (accessed_a)
   );

   dla_platform_csr_axi_stub #(
      .CSR_ADDR_WIDTH (11),
      .CSR_DATA_WIDTH (32),
      .ID_WIDTH       (1),
      .RESP           (2'b11),
      .RDATA_MODE     (1),
      .RDATA_PATTERN  (32'hDEAD_C5A0),
      .COUNT_WIDTH    (2)
   ) dut_b (
      .clk            (clk),
      .i_resetn_async (resetn),
      .csr            (bus_b),
      .o_rd_count     (rd_count_b),
      .o_wr_count     (wr_count_b),
      .o_accessed     (accessed_b)
   );

   typedef struct {
      logic        arvalid;
      logic        arid;
      logic [10:0] araddr;
      logic        rready;
      logic        awvalid;
      logic        awid;
      logic        wvalid;
      logic        bready;
      logic        e_arready;
      logic        e_rvalid;
      logic        e_rid;
      logic        e_awready;
      logic        e_wready;
      logic        e_bvalid;
      logic        e_bid;
      logic [15:0] e_rd_count;
      logic [15:0] e_wr_count;
      logic        e_accessed;
   } vec_t;

   localparam int NUM_VEC = 25;

   vec_t tbl [NUM_VEC];
   int   n_vectors     = 0;
   int   n_miscompares = 0;

   function automatic vec_t make_vec(
      input int arv, input int ari, input int ara, input int rr,
      input int awv, input int awi, input int wv, input int br,
      input int e_arr, input int e_rv, input int e_ri,
      input int e_awr, input int e_wr, input int e_bv, input int e_bi,
      input int e_rc, input int e_wc, input int e_acc
   );
      vec_t v;
      v.arvalid    = arv[0];
      v.arid       = ari[0];
      v.araddr     = 11'(ara);
      v.rready     = rr[0];
      v.awvalid    = awv[0];
      v.awid       = awi[0];
      v.wvalid     = wv[0];
      v.bready     = br[0];
      v.e_arready  = e_arr[0];
      v.e_rvalid   = e_rv[0];
      v.e_rid      = e_ri[0];
      v.e_awready  = e_awr[0];
      v.e_wready   = e_wr[0];
      v.e_bvalid   = e_bv[0];
      v.e_bid      = e_bi[0];
      v.e_rd_count = 16'(e_rc);
      v.e_wr_count = 16'(e_wc);
      v.e_accessed = e_acc[0];
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus_a.arvalid = v.arvalid;
      bus_a.arid    = v.arid;
      bus_a.araddr  = v.araddr;
      bus_a.rready  = v.rready;
      bus_a.awvalid = v.awvalid;
      bus_a.awid    = v.awid;
      bus_a.wvalid  = v.wvalid;
      bus_a.bready  = v.bready;
   endtask

   task automatic idleA();
      bus_a.arvalid = 1'b0;
      bus_a.arid    = 1'b0;
      bus_a.araddr  = '0;
      bus_a.rready  = 1'b0;
      bus_a.awvalid = 1'b0;
      bus_a.awid    = 1'b0;
      bus_a.wvalid  = 1'b0;
      bus_a.bready  = 1'b0;
   endtask

   task automatic idleB();
      bus_b.arvalid = 1'b0;
      bus_b.arid    = 1'b0;
      bus_b.araddr  = '0;
      bus_b.rready  = 1'b0;
      bus_b.awvalid = 1'b0;
      bus_b.awid    = 1'b0;
      bus_b.wvalid  = 1'b0;
      bus_b.bready  = 1'b0;
   endtask

   // Wait, within a bound, for both instances to reopen after reset release.
   task automatic waitReady(input string name);
      int cyc;
      cyc = 0;
      while (!(bus_a.arready && bus_b.arready) && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput(name, 80'({bus_a.arready, bus_b.arready}), 80'(2'b11));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic        id_q [$];
      logic        exp_id;
      int          sent;
      int          b_count;
      int          cyc;
      logic [1:0]  exp_wr;
      logic [1:0]  sat_seq [4];

      // Rows: arvalid arid araddr rready awvalid awid wvalid bready |
      //       arready rvalid rid awready wready bvalid bid rd_cnt wr_cnt accessed
      tbl[0]  = make_vec(0,0,'h000,1, 0,0,0,1,  1,0,0, 1,1,0,0, 0,0,0);
      tbl[1]  = make_vec(1,1,'h040,1, 0,0,0,1,  1,0,0, 1,1,0,0, 0,0,0);
      tbl[2]  = make_vec(0,0,'h000,1, 0,0,0,1,  0,1,1, 1,1,0,0, 0,0,1);
      tbl[3]  = make_vec(0,0,'h000,1, 0,0,0,1,  1,0,1, 1,1,0,0, 1,0,1);
      tbl[4]  = make_vec(1,0,'h010,0, 0,0,0,1,  1,0,1, 1,1,0,0, 1,0,1);
      tbl[5]  = make_vec(1,1,'h010,0, 0,0,0,1,  0,1,0, 1,1,0,0, 1,0,1);
      tbl[6]  = make_vec(1,1,'h010,1, 0,0,0,1,  0,1,0, 1,1,0,0, 1,0,1);
      tbl[7]  = make_vec(1,1,'h020,1, 0,0,0,1,  1,0,0, 1,1,0,0, 2,0,1);
      tbl[8]  = make_vec(0,0,'h000,1, 0,0,0,1,  0,1,1, 1,1,0,0, 2,0,1);
      tbl[9]  = make_vec(0,0,'h000,1, 0,0,0,1,  1,0,1, 1,1,0,0, 3,0,1);
      tbl[10] = make_vec(0,0,'h000,1, 1,1,1,1,  1,0,1, 1,1,0,0, 3,0,1);
      tbl[11] = make_vec(0,0,'h000,1, 0,0,0,1,  1,0,1, 0,0,0,0, 3,0,1);
      tbl[12] = make_vec(0,0,'h000,1, 0,0,0,1,  1,0,1, 0,0,1,1, 3,0,1);
      tbl[13] = make_vec(0,0,'h000,1, 0,0,0,1,  1,0,1, 1,1,0,1, 3,1,1);
      tbl[14] = make_vec(0,0,'h000,1, 1,0,0,0,  1,0,1, 1,1,0,1, 3,1,1);
      tbl[15] = make_vec(0,0,'h000,1, 0,0,1,0,  1,0,1, 0,1,0,1, 3,1,1);
      tbl[16] = make_vec(0,0,'h000,1, 0,0,0,0,  1,0,1, 0,0,0,1, 3,1,1);
      tbl[17] = make_vec(0,0,'h000,1, 1,1,1,0,  1,0,1, 0,0,1,0, 3,1,1);
      tbl[18] = make_vec(0,0,'h000,1, 1,1,1,0,  1,0,1, 0,0,1,0, 3,1,1);
      tbl[19] = make_vec(0,0,'h000,1, 1,1,1,1,  1,0,1, 0,0,1,0, 3,1,1);
      tbl[20] = make_vec(0,0,'h000,1, 1,1,1,1,  1,0,1, 1,1,0,0, 3,2,1);
      tbl[21] = make_vec(0,0,'h000,1, 0,0,0,1,  1,0,1, 0,0,0,0, 3,2,1);
      tbl[22] = make_vec(1,0,'h000,1, 0,0,0,1,  1,0,1, 0,0,1,1, 3,2,1);
      tbl[23] = make_vec(0,0,'h000,1, 0,0,0,1,  0,1,0, 1,1,0,1, 3,3,1);
      tbl[24] = make_vec(0,0,'h000,1, 0,0,0,1,  1,0,0, 1,1,0,1, 4,3,1);

      sat_seq[0] = 2'd2;
      sat_seq[1] = 2'd3;
      sat_seq[2] = 2'd3;
      sat_seq[3] = 2'd3;

      // Power-on reset
      resetn = 1'b0;
      idleA();
      idleB();
      repeat (3) @(negedge clk);
      checkOutput("reset_readies_low",
                  80'({bus_a.arready, bus_a.awready, bus_a.wready, bus_b.arready, bus_b.awready, bus_b.wready}),
                  80'(6'b000000));
      resetn = 1'b1;
      waitReady("reset_release");
      checkOutput("reset_state_a",
                  80'({bus_a.arready, bus_a.awready, bus_a.wready, bus_a.rvalid, bus_a.bvalid,
                       bus_a.rid, bus_a.bid, rd_count_a, wr_count_a, accessed_a}),
                  80'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0}));
      checkOutput("reset_state_b",
                  80'({bus_b.arready, bus_b.awready, bus_b.wready, bus_b.rvalid, bus_b.bvalid,
                       bus_b.rid, bus_b.bid, rd_count_b, wr_count_b, accessed_b}),
                  80'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0}));

      // Vector table on instance a: outputs depend only on state, so each
      // row checks the state left by the previous rows.
      for (int i = 0; i < NUM_VEC; i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("vec%0d", i),
                     80'({bus_a.arready, bus_a.rvalid, bus_a.rid, bus_a.rdata, bus_a.rresp,
                          bus_a.awready, bus_a.wready, bus_a.bvalid, bus_a.bid, bus_a.bresp,
                          rd_count_a, wr_count_a, accessed_a}),
                     80'({tbl[i].e_arready, tbl[i].e_rvalid, tbl[i].e_rid, 32'hDEAD_C5A0, 2'b00,
                          tbl[i].e_awready, tbl[i].e_wready, tbl[i].e_bvalid, tbl[i].e_bid, 2'b00,
                          tbl[i].e_rd_count, tbl[i].e_wr_count, tbl[i].e_accessed}));
         @(negedge clk);
      end
      idleA();

      // Instance b: address-mode read held by a stalled master
      bus_b.arvalid = 1'b1;
      bus_b.arid    = 1'b0;
      bus_b.araddr  = 11'h7FC;
      bus_b.rready  = 1'b0;
      @(negedge clk);
      bus_b.arid    = 1'b1;
      bus_b.araddr  = 11'h123;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("b_stall%0d", i),
                     80'({bus_b.rvalid, bus_b.arready, bus_b.rid, bus_b.rresp, bus_b.rdata}),
                     80'({1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_07FC}));
         @(negedge clk);
      end
      bus_b.arvalid = 1'b0;
      bus_b.rready  = 1'b1;
      @(negedge clk);
      bus_b.rready  = 1'b0;
      checkOutput("b_read_done",
                  80'({bus_b.rvalid, bus_b.arready, rd_count_b, accessed_b}),
                  80'({1'b0, 1'b1, 2'd1, 1'b1}));
      @(negedge clk);
      checkOutput("b_single_completion", 80'({bus_b.rvalid, rd_count_b}), 80'({1'b0, 2'd1}));

      // Instance b: counter saturation over four more reads
      for (int k = 0; k < 4; k++) begin
         bus_b.arvalid = 1'b1;
         bus_b.araddr  = 11'(k + 4);
         bus_b.rready  = 1'b1;
         @(negedge clk);
         bus_b.arvalid = 1'b0;
         checkOutput($sformatf("b_sat_data%0d", k),
                     80'({bus_b.rvalid, bus_b.rdata}), 80'({1'b1, 32'(k + 4)}));
         @(negedge clk);
         checkOutput($sformatf("b_sat_count%0d", k), 80'(rd_count_b), 80'(sat_seq[k]));
      end
      idleB();

      // Instance b: W at cycle 0, AW at cycle 3, a second W offered throughout
      bus_b.wvalid = 1'b1;
      @(negedge clk);
      checkOutput("b_wready_drop", 80'({bus_b.wready, bus_b.awready}), 80'(2'b01));
      @(negedge clk);
      @(negedge clk);
      bus_b.awvalid = 1'b1;
      bus_b.awid    = 1'b1;
      checkOutput("b_no_b_yet", 80'(bus_b.bvalid), 80'(1'b0));
      @(negedge clk);
      bus_b.awvalid = 1'b0;
      checkOutput("b_held_both", 80'({bus_b.awready, bus_b.wready, bus_b.bvalid}), 80'(3'b000));
      @(negedge clk);
      checkOutput("b_bvalid_at5",
                  80'({bus_b.bvalid, bus_b.bid, bus_b.bresp, bus_b.wready}),
                  80'({1'b1, 1'b1, 2'b11, 1'b0}));
      bus_b.bready = 1'b1;
      bus_b.wvalid = 1'b0;
      @(negedge clk);
      bus_b.bready = 1'b0;
      checkOutput("b_write_done",
                  80'({bus_b.bvalid, bus_b.awready, bus_b.wready, wr_count_b}),
                  80'({1'b0, 1'b1, 1'b1, 2'd1}));
      @(negedge clk);
      checkOutput("b_second_w_dropped", 80'({bus_b.wready, bus_b.bvalid}), 80'(2'b10));

      // Instance b: back-to-back write pairs with a random B ready
      sent    = 0;
      b_count = 0;
      cyc     = 0;
      exp_wr  = 2'd1;
      while (b_count < 8 && cyc < 300) begin
         bus_b.awvalid = (sent < 8);
         bus_b.wvalid  = (sent < 8);
         bus_b.awid    = sent[0];
         bus_b.bready  = 1'($urandom_range(0, 1));
         if (bus_b.awvalid && bus_b.awready && bus_b.wready) begin
            id_q.push_back(bus_b.awid);
            sent++;
         end
         if (bus_b.bvalid && bus_b.bready) begin
            exp_id = (id_q.size() > 0) ? id_q.pop_front() : 1'bx;
            checkOutput($sformatf("b_pair%0d", b_count),
                        80'({bus_b.bid, bus_b.bresp}), 80'({exp_id, 2'b11}));
            b_count++;
            if (exp_wr != 2'd3) exp_wr = exp_wr + 2'd1;
         end
         @(negedge clk);
         cyc++;
      end
      idleB();
      checkOutput("b_pairs_completed", 80'(b_count), 80'(8));
      checkOutput("b_wr_count_sat", 80'(wr_count_b), 80'(exp_wr));

      // Instance a: reset while a read response and a lone AW are in flight
      bus_a.arvalid = 1'b1;
      bus_a.arid    = 1'b1;
      bus_a.araddr  = 11'h008;
      bus_a.rready  = 1'b0;
      bus_a.awvalid = 1'b1;
      bus_a.awid    = 1'b1;
      @(negedge clk);
      idleA();
      checkOutput("a_inflight", 80'({bus_a.rvalid, bus_a.awready, bus_a.wready}), 80'(3'b101));
      resetn = 1'b0;
      #1;
      checkOutput("a_reset_readies_low", 80'({bus_a.wready, bus_b.arready}), 80'(2'b00));
      @(negedge clk);
      checkOutput("a_reset_flush",
                  80'({bus_a.rvalid, bus_a.bvalid, rd_count_a, wr_count_a, accessed_a, wr_count_b}),
                  80'({1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 2'd0}));
      resetn = 1'b1;
      waitReady("a_reset_release");
      checkOutput("a_post_reset_readies",
                  80'({bus_a.awready, bus_a.wready, bus_a.rvalid}), 80'(3'b110));

      // Fresh write pair after reset keeps the N+2 latency
      bus_a.awvalid = 1'b1;
      bus_a.awid    = 1'b1;
      bus_a.wvalid  = 1'b1;
      bus_a.bready  = 1'b1;
      @(negedge clk);
      bus_a.awvalid = 1'b0;
      bus_a.wvalid  = 1'b0;
      checkOutput("a_fresh_n1", 80'(bus_a.bvalid), 80'(1'b0));
      @(negedge clk);
      checkOutput("a_fresh_n2", 80'({bus_a.bvalid, bus_a.bid, bus_a.bresp}), 80'({1'b1, 1'b1, 2'b00}));
      @(negedge clk);
      checkOutput("a_fresh_done", 80'({bus_a.bvalid, wr_count_a}), 80'({1'b0, 16'd1}));
      idleA();

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule
